// File: rtl/threshold_slot_scheduler_if.sv
// threshold_slot_scheduler_if: pixel, config, processor and result signals of the slot scheduler
interface threshold_slot_scheduler_if;
  logic [10:0] x, y;
  logic [3:0] slot_enable;
  logic cfg_we;
  logic [1:0] cfg_slot;
  logic [2:0] cfg_field;
  logic [7:0] cfg_data;
  logic [10:0] proc_avgX, proc_avgY;
  logic proc_found;
  logic [7:0] C1LOW, C1HIGH, C2LOW, C2HIGH, C3LOW, C3HIGH;
  logic [1:0] active_slot;
  logic frame_start, result_valid;
  logic [1:0] result_slot;
  logic [10:0] result_x, result_y;
  logic result_found;
  modport master(
    output x, y, slot_enable, cfg_we, cfg_slot, cfg_field, cfg_data, proc_avgX, proc_avgY, proc_found,
    input C1LOW, C1HIGH, C2LOW, C2HIGH, C3LOW, C3HIGH, active_slot, frame_start, result_valid,
    input result_slot, result_x, result_y, result_found
  );
  modport slave(
    input x, y, slot_enable, cfg_we, cfg_slot, cfg_field, cfg_data, proc_avgX, proc_avgY, proc_found,
    output C1LOW, C1HIGH, C2LOW, C2HIGH, C3LOW, C3HIGH, active_slot, frame_start, result_valid,
    output result_slot, result_x, result_y, result_found
  );
endinterface

// File: rtl/threshold_slot_scheduler.sv
// threshold_slot_scheduler: frame-synchronous time-sharing of one threshold processor across four slots
module threshold_slot_scheduler #(
  parameter int FRAMES_PER_SLOT = 1,
  parameter logic [7:0] DEF_C1LOW = 8'd15,
  parameter logic [7:0] DEF_C1HIGH = 8'd250,
  parameter logic [7:0] DEF_C2LOW = 8'd8,
  parameter logic [7:0] DEF_C2HIGH = 8'd145,
  parameter logic [7:0] DEF_C3LOW = 8'd165,
  parameter logic [7:0] DEF_C3HIGH = 8'd248
) (
  input logic clock,
  input logic resetn,
  threshold_slot_scheduler_if.slave bus
);
  typedef enum logic [1:0] {IDLE, RUN, SETTLE} state_t;
  localparam logic [7:0] DEF [6] = '{DEF_C1LOW, DEF_C1HIGH, DEF_C2LOW, DEF_C2HIGH, DEF_C3LOW, DEF_C3HIGH};
  state_t state_q, state_d;
  logic [7:0] bank_q [4][6];
  logic [7:0] bank_d [4][6];
  logic [7:0] thr_q [6];
  logic [7:0] thr_d [6];
  logic [1:0] slot_q, slot_d, prev_slot_q, prev_slot_d, nxt, first;
  logic [3:0] cnt_q, cnt_d;
  logic prev_zero_q, prev_zero_d, go_idle_q, go_idle_d, sof;
  logic frame_start_q, frame_start_d, result_valid_q, result_valid_d, result_found_q, result_found_d;
  logic [1:0] result_slot_q, result_slot_d;
  logic [10:0] result_x_q, result_x_d, result_y_q, result_y_d;
  assign prev_zero_d = bus.x == 11'd0 && bus.y == 11'd0;
  assign sof = prev_zero_d && !prev_zero_q;
  assign frame_start_d = sof;
  assign result_valid_d = state_q == SETTLE;
  always_comb begin
    first = 2'd3;
    nxt = slot_q;
    for (int i = 3; i >= 0; i--) first = bus.slot_enable[i] ? 2'(i) : first;
    for (int i = 3; i >= 1; i--) nxt = bus.slot_enable[slot_q + 2'(i)] ? slot_q + 2'(i) : nxt;
    state_d = state_q;
    slot_d = slot_q;
    prev_slot_d = prev_slot_q;
    cnt_d = cnt_q;
    go_idle_d = go_idle_q;
    thr_d = thr_q;
    bank_d = bank_q;
    result_slot_d = result_slot_q;
    result_x_d = result_x_q;
    result_y_d = result_y_q;
    result_found_d = result_found_q;
    case (state_q)
      IDLE: if (sof && bus.slot_enable != 4'd0) begin
        state_d = RUN;
        slot_d = first;
        thr_d = bank_q[first];
        cnt_d = '0;
      end
      RUN: if (sof) begin
        state_d = SETTLE;
        prev_slot_d = slot_q;
        go_idle_d = bus.slot_enable == 4'd0;
        cnt_d = cnt_q + 4'd1;
        if (!go_idle_d && (cnt_d == 4'(FRAMES_PER_SLOT) || !bus.slot_enable[slot_q])) begin
          slot_d = nxt;
          thr_d = bank_q[nxt];
          cnt_d = '0;
        end
      end
      SETTLE: begin
        state_d = go_idle_q ? IDLE : RUN;
        result_slot_d = prev_slot_q;
        result_x_d = bus.proc_avgX;
        result_y_d = bus.proc_avgY;
        result_found_d = bus.proc_found;
      end
      default: state_d = IDLE;
    endcase
    // loads above read bank_q, so a same-cycle write is only seen by later loads
    if (bus.cfg_we && bus.cfg_field < 3'd6) bank_d[bus.cfg_slot][bus.cfg_field] = bus.cfg_data;
  end
  always_ff @(posedge clock) begin
    if (!resetn) begin
      state_q <= IDLE;
      for (int s = 0; s < 4; s++) bank_q[s] <= DEF;
      thr_q <= DEF;
      slot_q <= '0;
      prev_slot_q <= '0;
      cnt_q <= '0;
      go_idle_q <= 1'b0;
      prev_zero_q <= 1'b0;
      frame_start_q <= 1'b0;
      result_valid_q <= 1'b0;
      result_slot_q <= '0;
      result_x_q <= '0;
      result_y_q <= '0;
      result_found_q <= 1'b0;
    end else begin
      state_q <= state_d;
      bank_q <= bank_d;
      thr_q <= thr_d;
      slot_q <= slot_d;
      prev_slot_q <= prev_slot_d;
      cnt_q <= cnt_d;
      go_idle_q <= go_idle_d;
      prev_zero_q <= prev_zero_d;
      frame_start_q <= frame_start_d;
      result_valid_q <= result_valid_d;
      result_slot_q <= result_slot_d;
      result_x_q <= result_x_d;
      result_y_q <= result_y_d;
      result_found_q <= result_found_d;
    end
  end
  assign bus.C1LOW = thr_q[0];
  assign bus.C1HIGH = thr_q[1];
  assign bus.C2LOW = thr_q[2];
  assign bus.C2HIGH = thr_q[3];
  assign bus.C3LOW = thr_q[4];
  assign bus.C3HIGH = thr_q[5];
  assign bus.active_slot = slot_q;
  assign bus.frame_start = frame_start_q;
  assign bus.result_valid = result_valid_q;
  assign bus.result_slot = result_slot_q;
  assign bus.result_x = result_x_q;
  assign bus.result_y = result_y_q;
  assign bus.result_found = result_found_q;
endmodule

// File: tb/tb_threshold_slot_scheduler.sv
// tb_threshold_slot_scheduler: two schedulers (1 and 3 frames per slot) checked against a frame-level model
module tb_threshold_slot_scheduler;
  localparam logic [47:0] DEF_PACK = {8'd15, 8'd250, 8'd8, 8'd145, 8'd165, 8'd248};
  localparam logic [7:0] DEF [6] = '{8'd15, 8'd250, 8'd8, 8'd145, 8'd165, 8'd248};
  localparam int FPS [2] = '{1, 3};
  typedef struct packed {
    logic [1:0] slot, e_slot, rslot, e_rslot;
    logic [47:0] thr, e_thr;
    logic [10:0] rx, e_rx, ry, e_ry;
    logic rf, e_rf;
    int fs, e_fs, rv, e_rv;
  } frame_obs_t;
  logic clock = 0, resetn = 0;
  logic [10:0] x_i, y_i, px_i, py_i;
  logic [3:0] en_i;
  logic we_i, pf_i;
  logic [1:0] cs_i;
  logic [2:0] cf_i;
  logic [7:0] cd_i;
  int total = 0, bad = 0;
  threshold_slot_scheduler_if b0 ();
  threshold_slot_scheduler_if b1 ();
  threshold_slot_scheduler #(.FRAMES_PER_SLOT(1)) dut0 (.clock(clock), .resetn(resetn), .bus(b0));
  threshold_slot_scheduler #(.FRAMES_PER_SLOT(3)) dut1 (.clock(clock), .resetn(resetn), .bus(b1));
  assign b0.x = x_i; assign b0.y = y_i; assign b0.slot_enable = en_i; assign b0.cfg_we = we_i;
  assign b0.cfg_slot = cs_i; assign b0.cfg_field = cf_i; assign b0.cfg_data = cd_i;
  assign b0.proc_avgX = px_i; assign b0.proc_avgY = py_i; assign b0.proc_found = pf_i;
  assign b1.x = x_i; assign b1.y = y_i; assign b1.slot_enable = en_i; assign b1.cfg_we = we_i;
  assign b1.cfg_slot = cs_i; assign b1.cfg_field = cf_i; assign b1.cfg_data = cd_i;
  assign b1.proc_avgX = px_i; assign b1.proc_avgY = py_i; assign b1.proc_found = pf_i;
  logic [47:0] o_thr [2];
  logic [1:0] o_slot [2], o_rslot [2];
  logic o_fs [2], o_rv [2], o_rf [2];
  logic [10:0] o_rx [2], o_ry [2];
  assign o_thr[0] = {b0.C1LOW, b0.C1HIGH, b0.C2LOW, b0.C2HIGH, b0.C3LOW, b0.C3HIGH};
  assign o_thr[1] = {b1.C1LOW, b1.C1HIGH, b1.C2LOW, b1.C2HIGH, b1.C3LOW, b1.C3HIGH};
  assign o_slot[0] = b0.active_slot; assign o_slot[1] = b1.active_slot;
  assign o_fs[0] = b0.frame_start; assign o_fs[1] = b1.frame_start;
  assign o_rv[0] = b0.result_valid; assign o_rv[1] = b1.result_valid;
  assign o_rslot[0] = b0.result_slot; assign o_rslot[1] = b1.result_slot;
  assign o_rx[0] = b0.result_x; assign o_rx[1] = b1.result_x;
  assign o_ry[0] = b0.result_y; assign o_ry[1] = b1.result_y;
  assign o_rf[0] = b0.result_found; assign o_rf[1] = b1.result_found;
  always #5 clock = ~clock;

  // reference model: per-scheduler frame ownership, dwell count and bank contents
  bit m_was_zero, e_fs;
  bit m_run [2], m_settle [2], m_stop [2], e_rv [2], e_rf [2];
  logic [1:0] m_slot [2], m_owner [2], e_rslot [2];
  int m_dwell [2];
  logic [7:0] m_bank [2][4][6];
  logic [7:0] m_thr [2][6];
  logic [10:0] e_rx [2], e_ry [2];

  function automatic logic [1:0] lowest(input logic [3:0] en);
    for (int s = 0; s < 4; s++) if (en[s]) return 2'(s);
    return 2'd0;
  endfunction
  function automatic logic [1:0] next_rr(input logic [1:0] cur, input logic [3:0] en);
    for (int d = 1; d <= 4; d++) if (en[(int'(cur) + d) % 4]) return 2'((int'(cur) + d) % 4);
    return cur;
  endfunction
  function automatic logic [47:0] mthr(input int k);
    return {m_thr[k][0], m_thr[k][1], m_thr[k][2], m_thr[k][3], m_thr[k][4], m_thr[k][5]};
  endfunction
  task automatic load(input int k, input logic [1:0] s);
    m_slot[k] = s;
    m_dwell[k] = 0;
    for (int f = 0; f < 6; f++) m_thr[k][f] = m_bank[k][s][f];
  endtask

  task automatic tick();
    bit z, sof;
    @(posedge clock);
    z = x_i == 0 && y_i == 0;
    sof = z && !m_was_zero;
    if (!resetn) begin
      m_was_zero = 0;
      e_fs = 0;
      for (int k = 0; k < 2; k++) begin
        {m_run[k], m_settle[k], m_stop[k], e_rv[k], e_rf[k]} = '0;
        {m_slot[k], m_owner[k], e_rslot[k], e_rx[k], e_ry[k]} = '0;
        m_dwell[k] = 0;
        for (int s = 0; s < 4; s++) for (int f = 0; f < 6; f++) m_bank[k][s][f] = DEF[f];
        for (int f = 0; f < 6; f++) m_thr[k][f] = DEF[f];
      end
    end else begin
      m_was_zero = z;
      e_fs = sof;
      for (int k = 0; k < 2; k++) begin
        e_rv[k] = 0;
        if (m_settle[k]) begin
          e_rv[k] = 1; e_rslot[k] = m_owner[k]; e_rx[k] = px_i; e_ry[k] = py_i; e_rf[k] = pf_i;
          m_settle[k] = 0;
          m_run[k] = !m_stop[k];
        end else if (sof && m_run[k]) begin
          m_owner[k] = m_slot[k];
          m_settle[k] = 1;
          m_stop[k] = en_i == 0;
          m_dwell[k]++;
          if (en_i != 0 && (m_dwell[k] == FPS[k] || !en_i[m_slot[k]])) load(k, next_rr(m_slot[k], en_i));
        end else if (sof && en_i != 0) begin
          load(k, lowest(en_i));
          m_run[k] = 1;
        end
        if (we_i && cf_i < 6) m_bank[k][cs_i][cf_i] = cd_i;
      end
    end
    #1;
  endtask

  task automatic do_reset();
    resetn = 0; x_i = 1; y_i = 1; we_i = 0;
    tick();
    resetn = 1;
  endtask

  // one frame: (0,0) held for 'hold' cycles, then a raster walk; optional write in the SOF cycle
  task automatic drive_frame(input int k, input int hold, input logic [3:0] en_mid, input bit wr,
                             input logic [1:0] ws, input logic [2:0] wf, input logic [7:0] wd,
                             output frame_obs_t o);
    int len = int'($urandom_range(7, 12)) + hold;
    o = '0;
    for (int i = 0; i < len; i++) begin
      int p = i < hold ? 0 : i - hold + 1;
      x_i = 11'(p % 5); y_i = 11'(p / 5);
      px_i = 11'($urandom); py_i = 11'($urandom); pf_i = 1'($urandom);
      we_i = wr && i == 0; cs_i = ws; cf_i = wf; cd_i = wd;
      if (i == 3) en_i = en_mid;
      tick();
      if (i == 0) begin
        o.slot = o_slot[k]; o.e_slot = m_slot[k]; o.thr = o_thr[k]; o.e_thr = mthr(k);
      end
      o.fs += int'(o_fs[k]); o.e_fs += int'(e_fs);
      o.rv += int'(o_rv[k]); o.e_rv += int'(e_rv[k]);
      if (o_rv[k]) begin o.rslot = o_rslot[k]; o.rx = o_rx[k]; o.ry = o_ry[k]; o.rf = o_rf[k]; end
      if (e_rv[k]) begin o.e_rslot = e_rslot[k]; o.e_rx = e_rx[k]; o.e_ry = e_ry[k]; o.e_rf = e_rf[k]; end
    end
    we_i = 0;
  endtask

  task automatic test_reset();
    resetn = 0; x_i = 1; y_i = 1; en_i = 4'b1111; we_i = 0;
    tick(); tick();
    for (int k = 0; k < 2; k++) begin
      total++; if (o_thr[k] !== DEF_PACK) begin bad++; $display("FAIL reset_thr k=%0d got=%h exp=%h", k, o_thr[k], DEF_PACK); end
      total++; if (o_slot[k] !== 2'd0) begin bad++; $display("FAIL reset_slot k=%0d got=%0d exp=0", k, o_slot[k]); end
      total++; if ({o_fs[k], o_rv[k], o_rf[k], o_rslot[k], o_rx[k], o_ry[k]} !== '0) begin
        bad++; $display("FAIL reset_result k=%0d fs=%b rv=%b rf=%b rslot=%0d rx=%0d ry=%0d exp=all0", k, o_fs[k], o_rv[k], o_rf[k], o_rslot[k], o_rx[k], o_ry[k]);
      end
    end
    resetn = 1;
  endtask

  task automatic test_single_slot();
    frame_obs_t o;
    do_reset(); en_i = 4'b0001;
    drive_frame(0, 1, 4'b0001, 0, 0, 0, 0, o);
    total++; if (o.thr !== DEF_PACK) begin bad++; $display("FAIL single_thr1 got=%h exp=%h", o.thr, DEF_PACK); end
    total++; if (o.rv !== 0) begin bad++; $display("FAIL single_first_rv got=%0d exp=0", o.rv); end
    total++; if (o.fs !== 1) begin bad++; $display("FAIL single_fs got=%0d exp=1", o.fs); end
    drive_frame(0, 1, 4'b0001, 0, 0, 0, 0, o);
    total++; if (o.thr !== DEF_PACK) begin bad++; $display("FAIL single_thr2 got=%h exp=%h", o.thr, DEF_PACK); end
    total++; if (o.rv !== 1) begin bad++; $display("FAIL single_second_rv got=%0d exp=1", o.rv); end
    total++; if (o.rslot !== 2'd0) begin bad++; $display("FAIL single_rslot got=%0d exp=0", o.rslot); end
    total++; if ({o.rx, o.ry, o.rf} !== {o.e_rx, o.e_ry, o.e_rf}) begin
      bad++; $display("FAIL single_capture got=%0d/%0d/%b exp=%0d/%0d/%b", o.rx, o.ry, o.rf, o.e_rx, o.e_ry, o.e_rf);
    end
  endtask

  task automatic test_rotation();
    frame_obs_t o;
    logic [1:0] exp_s [5] = '{2'd0, 2'd1, 2'd3, 2'd0, 2'd1};
    do_reset(); en_i = 4'b1011;
    for (int f = 0; f < 5; f++) begin
      drive_frame(0, 1, 4'b1011, 0, 0, 0, 0, o);
      total++; if (o.slot !== exp_s[f]) begin bad++; $display("FAIL rot_slot f=%0d got=%0d exp=%0d", f, o.slot, exp_s[f]); end
      if (f > 0) begin
        total++; if (o.rv !== 1 || o.rslot !== exp_s[f-1]) begin
          bad++; $display("FAIL rot_result f=%0d rv=%0d rslot=%0d exp rv=1 rslot=%0d", f, o.rv, o.rslot, exp_s[f-1]);
        end
      end
    end
  endtask

  task automatic test_dwell();
    frame_obs_t o;
    logic [1:0] exp_s [7] = '{2'd0, 2'd0, 2'd0, 2'd2, 2'd2, 2'd2, 2'd0};
    do_reset(); en_i = 4'b0101;
    for (int f = 0; f < 7; f++) begin
      drive_frame(1, 1, 4'b0101, 0, 0, 0, 0, o);
      total++; if (o.slot !== exp_s[f]) begin bad++; $display("FAIL dwell_slot f=%0d got=%0d exp=%0d", f, o.slot, exp_s[f]); end
    end
  endtask

  task automatic test_cfg_write();
    frame_obs_t o;
    do_reset(); en_i = 4'b0011;
    drive_frame(0, 1, 4'b0011, 0, 0, 0, 0, o);
    drive_frame(0, 1, 4'b0011, 1, 2'd1, 3'd3, 8'd99, o);
    total++; if (o.slot !== 2'd1 || o.thr[23:16] !== 8'd145) begin
      bad++; $display("FAIL cfg_same_cycle slot=%0d c2high=%0d exp slot=1 c2high=145", o.slot, o.thr[23:16]);
    end
    drive_frame(0, 1, 4'b0011, 1, 2'd0, 3'd7, 8'd1, o);
    total++; if (o.thr !== DEF_PACK) begin bad++; $display("FAIL cfg_slot0_thr got=%h exp=%h", o.thr, DEF_PACK); end
    drive_frame(0, 1, 4'b0011, 0, 0, 0, 0, o);
    total++; if (o.slot !== 2'd1 || o.thr[23:16] !== 8'd99) begin
      bad++; $display("FAIL cfg_next_load slot=%0d c2high=%0d exp slot=1 c2high=99", o.slot, o.thr[23:16]);
    end
    total++; if (o.thr !== o.e_thr) begin bad++; $display("FAIL cfg_thr_model got=%h exp=%h", o.thr, o.e_thr); end
    drive_frame(0, 1, 4'b0011, 0, 0, 0, 0, o);
    total++; if (o.thr !== DEF_PACK) begin bad++; $display("FAIL cfg_field7 got=%h exp=%h", o.thr, DEF_PACK); end
  endtask

  task automatic test_hold_zero();
    frame_obs_t o;
    do_reset(); en_i = 4'b0001;
    drive_frame(0, 1, 4'b0001, 0, 0, 0, 0, o);
    drive_frame(0, 5, 4'b0001, 0, 0, 0, 0, o);
    total++; if (o.fs !== 1) begin bad++; $display("FAIL hold_fs got=%0d exp=1", o.fs); end
    total++; if (o.rv !== o.e_rv || o.rv > 1) begin bad++; $display("FAIL hold_rv got=%0d exp=%0d", o.rv, o.e_rv); end
  endtask

  task automatic test_disable();
    frame_obs_t o;
    drive_frame(0, 1, 4'b0000, 0, 0, 0, 0, o);
    drive_frame(0, 1, 4'b0000, 0, 0, 0, 0, o);
    total++; if (o.rv !== 1 || o.rslot !== 2'd0) begin
      bad++; $display("FAIL disable_last_result rv=%0d rslot=%0d exp rv=1 rslot=0", o.rv, o.rslot);
    end
    total++; if (o.slot !== 2'd0 || o.thr !== DEF_PACK) begin
      bad++; $display("FAIL disable_hold slot=%0d thr=%h exp slot=0 thr=%h", o.slot, o.thr, DEF_PACK);
    end
    for (int f = 0; f < 2; f++) begin
      drive_frame(0, 1, 4'b0000, 0, 0, 0, 0, o);
      total++; if (o.rv !== 0) begin bad++; $display("FAIL disable_idle_rv f=%0d got=%0d exp=0", f, o.rv); end
    end
  endtask

  task automatic test_reset_settle();
    frame_obs_t o;
    do_reset(); en_i = 4'b0001;
    drive_frame(0, 1, 4'b0001, 1, 2'd0, 3'd0, 8'd77, o);
    x_i = 0; y_i = 0;
    tick();
    total++; if (o_thr[0][47:40] !== 8'd77) begin bad++; $display("FAIL rs_reload c1low=%0d exp=77", o_thr[0][47:40]); end
    resetn = 0; x_i = 1;
    tick();
    resetn = 1;
    total++; if (o_rv[0] !== 1'b0 || o_thr[0] !== DEF_PACK || o_slot[0] !== 2'd0) begin
      bad++; $display("FAIL rs_in_reset rv=%b thr=%h slot=%0d exp rv=0 thr=%h slot=0", o_rv[0], o_thr[0], o_slot[0], DEF_PACK);
    end
    tick();
    total++; if (o_rv[0] !== 1'b0) begin bad++; $display("FAIL rs_after_rv got=%b exp=0", o_rv[0]); end
    drive_frame(0, 1, 4'b0001, 0, 0, 0, 0, o);
    total++; if (o.thr !== DEF_PACK || o.rv !== 0) begin
      bad++; $display("FAIL rs_bank_default thr=%h rv=%0d exp thr=%h rv=0", o.thr, o.rv, DEF_PACK);
    end
  endtask

  task automatic test_random();
    frame_obs_t o;
    do_reset(); en_i = 4'b1111;
    for (int f = 0; f < 40; f++) begin
      int k = f % 2;
      if ($urandom_range(0, 3) == 0) en_i = 4'($urandom);
      drive_frame(k, int'($urandom_range(1, 3)), en_i, 1'($urandom), 2'($urandom), 3'($urandom), 8'($urandom), o);
      total++; if (o.slot !== o.e_slot || o.thr !== o.e_thr) begin
        bad++; $display("FAIL rand_load f=%0d k=%0d slot=%0d thr=%h exp slot=%0d thr=%h", f, k, o.slot, o.thr, o.e_slot, o.e_thr);
      end
      total++; if (o.rv !== o.e_rv || o.fs !== o.e_fs) begin
        bad++; $display("FAIL rand_pulses f=%0d k=%0d rv=%0d fs=%0d exp rv=%0d fs=%0d", f, k, o.rv, o.fs, o.e_rv, o.e_fs);
      end
      if (o.e_rv > 0) begin
        total++; if ({o.rslot, o.rx, o.ry, o.rf} !== {o.e_rslot, o.e_rx, o.e_ry, o.e_rf}) begin
          bad++; $display("FAIL rand_result f=%0d k=%0d got=%0d/%0d/%0d/%b exp=%0d/%0d/%0d/%b", f, k, o.rslot, o.rx, o.ry, o.rf, o.e_rslot, o.e_rx, o.e_ry, o.e_rf);
        end
      end
    end
  endtask

  initial begin
    x_i = 1; y_i = 1; en_i = 0; we_i = 0; cs_i = 0; cf_i = 0; cd_i = 0; px_i = 0; py_i = 0; pf_i = 0;
    test_reset();
    test_single_slot();
    test_rotation();
    test_dwell();
    test_cfg_write();
    test_hold_zero();
    test_disable();
    test_reset_settle();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/threshold_slot_scheduler.md
Name: threshold_slot_scheduler

Overview:
- Time-shares the single colour-threshold/blob-tracking image processor between up to 4 target profiles ("slots"), switching slots only on frame boundaries.
- Holds a writable bank of 6 threshold bytes per slot and drives the active set onto the processor's C1LOW..C3HIGH inputs.
- At each frame boundary, captures the processor's averaged X/Y and found flag, tags the result with the slot that owned the finished frame, and emits a one-cycle result pulse.

Parameters:
- FRAMES_PER_SLOT, 1, frames each slot owns before rotating (legal 1..15).
- DEF_C1LOW, 15 / DEF_C1HIGH, 250, reset contents of every slot's C1 bounds.
- DEF_C2LOW, 8 / DEF_C2HIGH, 145, reset contents of every slot's C2 bounds.
- DEF_C3LOW, 165 / DEF_C3HIGH, 248, reset contents of every slot's C3 bounds.

Ports:
- clock  in  1  system clock, all logic on posedge
- resetn  in  1  synchronous reset, active-low
- x  in  11  current pixel column (shared with processor)
- y  in  11  current pixel row (shared with processor)
- slot_enable  in  4  per-slot enable, bit i = slot i
- cfg_we  in  1  threshold bank write strobe
- cfg_slot  in  2  slot to write
- cfg_field  in  3  0=C1LOW 1=C1HIGH 2=C2LOW 3=C2HIGH 4=C3LOW 5=C3HIGH; 6,7 ignored
- cfg_data  in  8  write data
- proc_avgX  in  11  processor averaged X
- proc_avgY  in  11  processor averaged Y
- proc_found  in  1  processor target-found flag
- C1LOW, C1HIGH, C2LOW, C2HIGH, C3LOW, C3HIGH  out  8 each  active thresholds to processor (registered)
- active_slot  out  2  slot owning the current frame
- frame_start  out  1  one-cycle pulse, cycle after SOF detected
- result_valid  out  1  one-cycle result strobe
- result_slot  out  2  slot that owned the finished frame
- result_x, result_y  out  11 each  captured proc_avgX/Y
- result_found  out  1  captured proc_found

Behaviour:
- Reset (resetn=0 at posedge): state IDLE; all bank entries = DEF_*; threshold outputs = DEF_*; active_slot=0; dwell counter=0; frame_start, result_valid, result_* all 0; prev-zero flag cleared. Reset mid-frame abandons the frame, with no result.
- SOF: asserted in cycle N when x==0 && y==0 and registered prev-zero flag is 0. Coordinates holding at (0,0) for several cycles give a single SOF.
- frame_start is high in cycle N+1 only, in every state.
- IDLE:
  - on SOF with slot_enable!=0: load the lowest enabled slot into active_slot and the thresholds; dwell counter=0; go to RUN.
  - No result is emitted, because no frame was owned.
- RUN:
  - on SOF: go to SETTLE.
  - Dwell counter +1. If it reaches FRAMES_PER_SLOT, or the current slot is now disabled, pick the next enabled slot in round-robin order after the current one (wrap 3->0) and clear the counter. Otherwise keep the slot.
  - active_slot and thresholds update on the edge ending cycle N, so they are valid from N+1.
  - prev_slot is latched with the old slot.
  - If slot_enable==0: the SETTLE exit goes to IDLE; active_slot and thresholds hold.
- SETTLE:
  - One cycle (N+1), during which processor outputs are valid.
  - Capture proc_avgX/Y and proc_found into result_*, with result_slot=prev_slot.
  - result_valid is high in cycle N+2 only.
  - Go to RUN, or to IDLE per the rule above. SOF during SETTLE is ignored.
- Config writes:
  - Write to bank[cfg_slot][cfg_field] on the posedge where cfg_we=1; fields 6/7 are no-ops.
  - The bank is never read directly by the processor. A write to the active slot takes effect at the next slot load only.
  - A write in the same cycle as a load is not seen by that load, which uses pre-write contents.
- Slot selection with a single enabled slot reloads the same slot, picking up new bank values.
- No arithmetic beyond the 4-bit dwell counter; widths as listed; no truncation.

Test Plan:
- Reset, slot_enable=4'b0001, two frames (x,y sweep, SOF at each (0,0)) -> thresholds stay 15/250/8/145/165/248; first SOF gives no result_valid; second SOF gives result_valid in N+2 with result_slot=0 and result_x/y = proc_avgX/Y presented at N+1.
- slot_enable=4'b1011, FRAMES_PER_SLOT=1, 5 frames -> active_slot sequence 0,1,3,0,1; result_slot lags by one frame: 0,1,3,0.
- FRAMES_PER_SLOT=3, slots 0,2 enabled, 7 frames -> active_slot 0,0,0,2,2,2,0.
- cfg_we write slot1 field3 = 8'd99 in the SOF cycle that loads slot1 -> C2HIGH=145 for that frame; on the next load of slot1, C2HIGH=99. A field=7 write leaves the bank unchanged.
- (x,y) held at (0,0) for 5 cycles -> exactly one frame_start and at most one result_valid. Clearing slot_enable mid-frame -> at the next SOF the result is emitted, then IDLE; no further results.
- resetn low during SETTLE -> result_valid stays 0, state IDLE, bank back to defaults.
